// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: one-bit-per-clock PRBS7/15/31, clock and low-frequency pattern source with burst control.
// Single-bit error injection is compiled in only when PATGEN_ERR_INJECT_EN is defined.
module serial_pattern_gen #(
    parameter int BURST_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [2:0]         mode_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               inj_req_i,
    output logic               inj_ack_o,
    output logic               serial_out_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [BURST_W-1:0] bits_sent_o,
    output logic [BURST_W-1:0] trans_count_o,
    output logic [15:0]        inj_count_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e             state_q;
    logic [2:0]         mode_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] bits_q;
    logic [BURST_W-1:0] trans_q;
    logic [30:0]        lfsr_q;
    logic [3:0]         phase_q;
    logic [3:0]         phase_d;
    logic               serial_q;
    logic               busy_q;
    logic               done_q;

    logic               lfsrNew_d;
    logic               patBit_d;
    logic               txBit_d;
    logic               lastBit_d;
    logic               burstEnd_d;
    logic               emit_d;

`ifdef PATGEN_ERR_INJECT_EN
    logic               ack_q;
    logic [15:0]        injCnt_q;

    assign txBit_d     = patBit_d ^ inj_req_i;
    assign inj_ack_o   = ack_q;
    assign inj_count_o = injCnt_q;
`else
    logic               unusedInjReq;

    assign unusedInjReq = inj_req_i;
    assign txBit_d      = patBit_d;
    assign inj_ack_o    = 1'b0;
    assign inj_count_o  = '0;
`endif

    // A stop that lands on the final bit of a bounded burst lets that bit go out; the burst then ends normally.
    always_comb begin
        lfsrNew_d = 1'b0;
        patBit_d  = 1'b0;
        phase_d   = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
        case (mode_q)
            3'd0:    lfsrNew_d = lfsr_q[6]  ^ lfsr_q[5];
            3'd1:    lfsrNew_d = lfsr_q[14] ^ lfsr_q[13];
            3'd2:    lfsrNew_d = lfsr_q[30] ^ lfsr_q[27];
            default: lfsrNew_d = 1'b0;
        endcase
        case (mode_q)
            3'd0, 3'd1, 3'd2: patBit_d = lfsrNew_d;
            3'd3:             patBit_d = ~phase_q[0];
            3'd4:             patBit_d = (phase_q < 4'd5);
            default:          patBit_d = 1'b0;
        endcase
        lastBit_d  = (len_q != '0) && (bits_q == len_q - BURST_W'(1));
        burstEnd_d = (len_q != '0) && (bits_q == len_q);
        emit_d     = (state_q == RUN) && !burstEnd_d && !(stop_i && !lastBit_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            len_q    <= '0;
            bits_q   <= '0;
            trans_q  <= '0;
            lfsr_q   <= '1;
            phase_q  <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PATGEN_ERR_INJECT_EN
            ack_q    <= 1'b0;
            injCnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef PATGEN_ERR_INJECT_EN
            ack_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    serial_q <= 1'b0;
                    if (start_i) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    mode_q   <= mode_i;
                    len_q    <= burst_len_i;
                    lfsr_q   <= '1;
                    phase_q  <= '0;
                    bits_q   <= '0;
                    trans_q  <= '0;
`ifdef PATGEN_ERR_INJECT_EN
                    injCnt_q <= '0;
`endif
                    state_q  <= RUN;
                end
                RUN: begin
                    if (emit_d) begin
                        serial_q <= txBit_d;
                        lfsr_q   <= {lfsr_q[29:0], lfsrNew_d};
                        phase_q  <= phase_d;
                        if (bits_q != '1)
                            bits_q <= bits_q + BURST_W'(1);
                        if ((txBit_d != serial_q) && (trans_q != '1))
                            trans_q <= trans_q + BURST_W'(1);
`ifdef PATGEN_ERR_INJECT_EN
                        if (inj_req_i) begin
                            ack_q <= 1'b1;
                            if (injCnt_q != '1)
                                injCnt_q <= injCnt_q + 16'd1;
                        end
`endif
                    end else begin
                        state_q  <= DONE;
                        serial_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign serial_out_o  = serial_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign bits_sent_o   = bits_q;
    assign trans_count_o = trans_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: randomized bursts with a queue-based scoreboard; expected traces come from
// the pattern recurrences and burst timing rules, and a free-running monitor compares every cycle.
module tb_serial_pattern_gen;

    localparam int BW = 32;

`ifdef PATGEN_ERR_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [2:0]    mode_i = '0;
    logic [BW-1:0] burst_len_i = '0;
    logic          inj_req_i = 1'b0;
    logic          inj_ack_o;
    logic          serial_out_o;
    logic          busy_o;
    logic          done_o;
    logic [BW-1:0] bits_sent_o;
    logic [BW-1:0] trans_count_o;
    logic [15:0]   inj_count_o;

    serial_pattern_gen #(.BURST_W(BW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .mode_i       (mode_i),
        .burst_len_i  (burst_len_i),
        .inj_req_i    (inj_req_i),
        .inj_ack_o    (inj_ack_o),
        .serial_out_o (serial_out_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bits_sent_o  (bits_sent_o),
        .trans_count_o(trans_count_o),
        .inj_count_o  (inj_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        done;
        logic        ser;
        logic        ack;
        logic [31:0] bits;
        logic [31:0] trans;
        logic [15:0] inj;
        bit          chkCnt;
    } exp_t;

    exp_t sbQ[$];
    bit   injPlan[0:2047];
    int   compared = 0;
    int   mismatched = 0;
    int   burstId = 0;
    int   recIdx = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL burst %0d rec %0d %s: got %0h expected %0h", burstId, recIdx, name, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle while a burst trace is queued.
    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            recIdx++;
            checkOutput("busy", 32'(busy_o), 32'(e.busy));
            checkOutput("done", 32'(done_o), 32'(e.done));
            checkOutput("serial_out", 32'(serial_out_o), 32'(e.ser));
            checkOutput("inj_ack", 32'(inj_ack_o), 32'(e.ack));
            if (e.chkCnt) begin
                checkOutput("bits_sent", bits_sent_o, e.bits);
                checkOutput("trans_count", trans_count_o, e.trans);
                checkOutput("inj_count", 32'(inj_count_o), 32'(e.inj));
            end
        end
    end

    function automatic exp_t mkRec(input logic b, input logic d, input logic s, input logic a,
                                   input int nb, input int nt, input int ni, input bit c);
        exp_t r;
        r.busy = b; r.done = d; r.ser = s; r.ack = a;
        r.bits = 32'(nb); r.trans = 32'(nt); r.inj = 16'(ni); r.chkCnt = c;
        return r;
    endfunction

    // Reference: b[n] = b[n-N] ^ b[n-T] with every bit before the burst taken as 1 (all-ones seed).
    function automatic int pushExpected(input int md, input int len, input bit hasStop, input int stopAt);
        bit seq[0:2047];
        int n, t, nBits, trans, injc;
        bit prev, p, inv, o, a, b;
        n = (md == 0) ? 7 : (md == 1) ? 15 : 31;
        t = (md == 0) ? 6 : (md == 1) ? 14 : 28;
        if (len != 0) nBits = (hasStop && stopAt < len - 1) ? stopAt : len;
        else          nBits = stopAt;
        trans = 0; injc = 0; prev = 1'b0;
        sbQ.push_back(mkRec(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0));
        sbQ.push_back(mkRec(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1));
        for (int i = 0; i < nBits; i++) begin
            case (md)
                0, 1, 2: begin
                    a = (i - n < 0) ? 1'b1 : seq[i - n];
                    b = (i - t < 0) ? 1'b1 : seq[i - t];
                    p = a ^ b;
                end
                3:       p = (i % 2 == 0);
                4:       p = ((i % 10) < 5);
                default: p = 1'b0;
            endcase
            seq[i] = p;
            inv = INJ_ON && injPlan[i + 2];
            o = p ^ inv;
            if (o != prev) trans++;
            prev = o;
            if (inv) injc++;
            sbQ.push_back(mkRec(1'b1, 1'b0, o, inv, i + 1, trans, injc, 1'b1));
        end
        sbQ.push_back(mkRec(1'b1, 1'b1, 1'b0, 1'b0, nBits, trans, injc, 1'b1));
        sbQ.push_back(mkRec(1'b0, 1'b0, 1'b0, 1'b0, nBits, trans, injc, 1'b1));
        sbQ.push_back(mkRec(1'b0, 1'b0, 1'b0, 1'b0, nBits, trans, injc, 1'b1));
        return nBits;
    endfunction

    // injBit: -1 sparse random requests, -2 none, otherwise only on that bit index.
    task automatic planInj(input int injBit);
        for (int c = 0; c < 2048; c++) begin
            if (injBit == -1) injPlan[c] = ($urandom_range(0, 5) == 0);
            else              injPlan[c] = 1'b0;
        end
        if (injBit >= 0) injPlan[injBit + 2] = 1'b1;
    endtask

    task automatic waitDrain();
        int w = 0;
        while (sbQ.size() != 0 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL burst %0d drain: %0d records left expected 0", burstId, sbQ.size());
            sbQ.delete();
        end
    endtask

    // Drive cycle c is sampled at edge k+c, where k is the edge that sees start.
    task automatic applyStimulus(input int md, input int len, input bit hasStop, input int stopAt, input int injBit);
        int nBits;
        burstId++;
        recIdx = 0;
        planInj(injBit);
        mode_i      = 3'(md);
        burst_len_i = BW'(len);
        start_i     = 1'b1;
        stop_i      = 1'b0;
        inj_req_i   = injPlan[0];
        @(posedge clk); #1;
        nBits = pushExpected(md, len, hasStop, stopAt);
        for (int c = 1; c <= 4 + nBits; c++) begin
            start_i = (c <= 3 + nBits) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c >= 2) begin
                mode_i      = 3'($urandom);
                burst_len_i = BW'($urandom);
            end
            stop_i    = (hasStop && (c - 2 == stopAt)) ||
                        (((c == 1) || (c >= 3 + nBits)) && ($urandom_range(0, 1) == 1));
            inj_req_i = injPlan[c];
            @(posedge clk); #1;
        end
        start_i   = 1'b0;
        stop_i    = 1'b0;
        inj_req_i = 1'b0;
        waitDrain();
    endtask

    task automatic checkAllZero(input string tag);
        recIdx = 0;
        checkOutput({tag, " serial_out"}, 32'(serial_out_o), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, " done"}, 32'(done_o), 32'd0);
        checkOutput({tag, " inj_ack"}, 32'(inj_ack_o), 32'd0);
        checkOutput({tag, " bits_sent"}, bits_sent_o, 32'd0);
        checkOutput({tag, " trans_count"}, trans_count_o, 32'd0);
        checkOutput({tag, " inj_count"}, 32'(inj_count_o), 32'd0);
    endtask

    task automatic resetMidBurst();
        int nBits;
        burstId++;
        recIdx = 0;
        planInj(-2);
        mode_i      = 3'd1;
        burst_len_i = BW'(60);
        start_i     = 1'b1;
        @(posedge clk); #1;
        nBits = pushExpected(1, 60, 1'b0, 0);
        start_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        sbQ.delete();
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1, 60, 1'b0, 0, -2);
        if (nBits != 60) $display("[TB] note: unexpected plan length %0d", nBits);
    endtask

    initial begin
        int md, len, sa;
        bit hs;
        $display("[TB] serial_pattern_gen bench, injection %s", INJ_ON ? "enabled" : "disabled");
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkAllZero("after_reset");

        applyStimulus(0, 7, 1'b0, 0, -2);
        applyStimulus(3, 8, 1'b0, 0, -2);
        applyStimulus(4, 20, 1'b0, 0, -2);
        applyStimulus(2, 0, 1'b1, 1000, -2);
        applyStimulus(3, 8, 1'b0, 0, 2);
        applyStimulus(3, 8, 1'b1, 7, -2);
        applyStimulus(0, 10, 1'b1, 3, -1);
        applyStimulus(4, 5, 1'b1, 0, -1);
        applyStimulus(6, 12, 1'b0, 0, -1);

        for (int r = 0; r < 24; r++) begin
            md  = $urandom_range(0, 7);
            len = $urandom_range(0, 120);
            hs  = 1'($urandom_range(0, 1));
            if (len == 0) hs = 1'b1;
            sa  = $urandom_range(0, (len == 0) ? 120 : len + 1);
            applyStimulus(md, len, hs, sa, -1);
        end

        resetMidBurst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
